// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed scores, one beat per class in order.
// Reports the winning index and score for one cycle in DONE, then holds them.
module argmax_classifier #(
  parameter int DATA_WIDTH_output = 8,
  parameter int NUM_CLASSES       = 10,
  parameter int OUT_W             = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic signed [DATA_WIDTH_output-1:0] in_data,
  output logic                                in_ready,
  output logic [OUT_W-1:0]                    out,
  output logic                                out_valid,
  output logic signed [DATA_WIDTH_output-1:0] max_score,
  output logic                                busy,
  output logic                                err
);

  localparam int CNT_W = $clog2(NUM_CLASSES) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [OUT_W-1:0]                    best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH_output-1:0] best_score_q, best_score_d;
  logic [OUT_W-1:0]                    out_q, out_d;
  logic signed [DATA_WIDTH_output-1:0] max_score_q, max_score_d;
  logic                                err_q, err_d;
  logic                                accept, last_beat, take;

  // First beat always wins; later beats need a strictly larger score so ties keep the lower index.
  function automatic logic beats_best(input logic                                first,
                                      input logic signed [DATA_WIDTH_output-1:0] cand,
                                      input logic signed [DATA_WIDTH_output-1:0] best);
    return first || (cand > best);
  endfunction

  assign accept    = in_valid && (state_q == ACCUM);
  assign last_beat = accept && !start && (cnt_q == CNT_W'(NUM_CLASSES - 1));
  assign take      = accept && beats_best(cnt_q == '0, in_data, best_score_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DONE;
      DONE:    state_d = start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  // Result registers load on the last beat's edge so out/max_score are already valid during DONE.
  always_comb begin
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    out_d        = out_q;
    max_score_d  = max_score_q;
    err_d        = err_q;
    if (start) begin
      cnt_d        = '0;
      best_idx_d   = '0;
      best_score_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      if (take) begin
        best_idx_d   = OUT_W'(cnt_q);
        best_score_d = in_data;
      end
      if (last_beat) begin
        out_d       = take ? OUT_W'(cnt_q) : best_idx_q;
        max_score_d = take ? in_data : best_score_q;
      end
    end
    if (start) err_d = 1'b0;
    if (in_valid && (state_q != ACCUM)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      out_q        <= '0;
      max_score_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      out_q        <= out_d;
      max_score_q  <= max_score_d;
      err_q        <= err_d;
    end
  end

  assign out       = out_q;
  assign max_score = max_score_q;
  assign err       = err_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed scenarios plus randomized
// score sequences compared against a max-then-first-index reference model.
module tb_argmax_classifier;
  localparam int DW = 8;
  localparam int NC = 10;
  localparam int OW = 4;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready, out_valid, busy, err;
  logic [OW-1:0]        out;
  logic signed [DW-1:0] max_score;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;

  logic signed [DW-1:0] scores [NC];
  logic [OW-1:0]        exp_out, last_out;
  logic signed [DW-1:0] exp_max, last_max;

  argmax_classifier #(.DATA_WIDTH_output(DW), .NUM_CLASSES(NC), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .max_score(max_score),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid === 1'b1) ov_cnt++;

  // Reference: find the maximum value, then the lowest class index holding it.
  function automatic void ref_model(output logic [OW-1:0] idx, output logic signed [DW-1:0] mx);
    mx = scores[0];
    for (int k = 1; k < NC; k++) if (scores[k] > mx) mx = scores[k];
    idx = '0;
    for (int k = NC - 1; k >= 0; k--) if (scores[k] == mx) idx = OW'(k);
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sends beats 0..n-1 of scores[], with up to gap_max idle cycles before each beat.
  task automatic send_scores(input int n, input int gap_max);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = scores[k];
      @(posedge clk);
    end
    @(negedge clk) in_valid = 1'b0;
  endtask

  // Full classification: start, all beats, then check DONE cycle and the hold cycle.
  task automatic classify(input string name, input int gap_max);
    int ov0;
    ref_model(exp_out, exp_max);
    pulse_start();
    ov0 = ov_cnt;
    send_scores(NC, gap_max);
    checks++;
    if (out_valid !== 1'b1 || out !== exp_out || max_score !== exp_max) begin
      errors++;
      $display("FAIL %s done: out_valid=%b out=%0d max=%0d expected out_valid=1 out=%0d max=%0d",
               name, out_valid, out, max_score, exp_out, exp_max);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out !== exp_out || max_score !== exp_max ||
        ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL %s after: out_valid=%b busy=%b out=%0d max=%0d pulses=%0d expected 0 0 %0d %0d 1",
               name, out_valid, busy, out, max_score, ov_cnt - ov0, exp_out, exp_max);
    end
    last_out = exp_out;
    last_max = exp_max;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, busy, err, in_ready} !== 4'b0000 || out !== '0 || max_score !== '0) begin
      errors++;
      $display("FAIL reset: ov/busy/err/rdy=%b%b%b%b out=%0d max=%0d expected 0000 0 0",
               out_valid, busy, err, in_ready, out, max_score);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
    last_out = '0;
    last_max = '0;
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] v [NC] = '{3, -5, 12, 7, 0, -1, 9, 2, 11, 4};
    for (int k = 0; k < NC; k++) scores[k] = v[k];
    classify("basic", 0);
    checks++;
    if (out !== 4'd2 || max_score !== 8'sd12) begin
      errors++;
      $display("FAIL basic_const: out=%0d max=%0d expected 2 12", out, max_score);
    end
  endtask

  task automatic test_boundaries();
    for (int k = 0; k < NC; k++) scores[k] = -8'sd128;
    classify("all_min", 0);
    checks++;
    if (out !== 4'd0 || max_score !== -8'sd128) begin
      errors++;
      $display("FAIL all_min_const: out=%0d max=%0d expected 0 -128", out, max_score);
    end
    for (int k = 0; k < NC; k++) scores[k] = 8'sd1;
    scores[4] = 8'sd5;
    scores[7] = 8'sd5;
    classify("tie", 0);
    checks++;
    if (out !== 4'd4) begin
      errors++;
      $display("FAIL tie_const: out=%0d expected 4", out);
    end
    for (int k = 0; k < NC; k++) scores[k] = -8'sd100;
    scores[NC-1] = -8'sd50;
    classify("last_wins", 0);
  endtask

  task automatic test_gaps();
    for (int k = 0; k < NC - 1; k++) scores[k] = DW'($urandom_range(254, 0) - 128);
    scores[NC-1] = 8'sd127;
    classify("gaps", 4);
    checks++;
    if (out !== 4'd9 || max_score !== 8'sd127) begin
      errors++;
      $display("FAIL gaps_const: out=%0d max=%0d expected 9 127", out, max_score);
    end
  endtask

  task automatic test_restart();
    int ov0;
    for (int k = 0; k < NC; k++) scores[k] = 8'sd10;
    scores[1] = 8'sd50;
    pulse_start();
    ov0 = ov_cnt;
    send_scores(5, 1);
    for (int k = 0; k < NC; k++) scores[k] = DW'($urandom_range(147, 0) - 128);
    scores[6] = 8'sd20;
    classify("restart", 1);
    checks++;
    if (out !== 4'd6 || max_score !== 8'sd20 || ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL restart_const: out=%0d max=%0d pulses=%0d expected 6 20 1",
               out, max_score, ov_cnt - ov0);
    end
  endtask

  task automatic test_idle_err();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'sd99;
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || out !== last_out || max_score !== last_max || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_err: err=%b out=%0d max=%0d ov=%b expected 1 %0d %0d 0",
               err, out, max_score, out_valid, last_out, last_max);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: err=%b in_ready=%b busy=%b expected 0 1 1", err, in_ready, busy);
    end
    for (int k = 0; k < NC; k++) scores[k] = DW'($urandom);
    ref_model(exp_out, exp_max);
    send_scores(NC, 0);
    checks++;
    if (out_valid !== 1'b1 || out !== exp_out || max_score !== exp_max) begin
      errors++;
      $display("FAIL after_err: out=%0d max=%0d expected %0d %0d", out, max_score, exp_out, exp_max);
    end
    @(negedge clk);
    last_out = exp_out;
    last_max = exp_max;
  endtask

  task automatic test_rst_mid();
    int ov0;
    for (int k = 0; k < NC; k++) scores[k] = 8'sd100;
    pulse_start();
    ov0 = ov_cnt;
    send_scores(6, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, err, in_ready} !== 4'b0000 || out !== '0 || max_score !== '0) begin
      errors++;
      $display("FAIL rst_mid: ov/busy/err/rdy=%b%b%b%b out=%0d max=%0d expected 0000 0 0",
               out_valid, busy, err, in_ready, out, max_score);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ov_cnt != ov0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_pulse: pulses=%0d busy=%b expected 0 0", ov_cnt - ov0, busy);
    end
    for (int k = 0; k < NC; k++) scores[k] = DW'($urandom);
    classify("post_rst", 0);
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0]        e_out;
    logic signed [DW-1:0] e_max;
    for (int k = 0; k < NC; k++) scores[k] = DW'($urandom);
    ref_model(e_out, e_max);
    pulse_start();
    send_scores(NC, 0);
    start = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out !== e_out || max_score !== e_max) begin
      errors++;
      $display("FAIL start_in_done: ov=%b out=%0d max=%0d expected 1 %0d %0d",
               out_valid, out, max_score, e_out, e_max);
    end
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_to_accum: in_ready=%b ov=%b expected 1 0", in_ready, out_valid);
    end
    for (int k = 0; k < NC; k++) scores[k] = DW'($urandom);
    ref_model(exp_out, exp_max);
    send_scores(NC, 0);
    checks++;
    if (out_valid !== 1'b1 || out !== exp_out || max_score !== exp_max) begin
      errors++;
      $display("FAIL b2b_second: out=%0d max=%0d expected %0d %0d", out, max_score, exp_out, exp_max);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < NC; k++) begin
        scores[k] = DW'($urandom);
        if ($urandom_range(7, 0) == 0) scores[k] = scores[$urandom_range(NC - 1, 0)];
      end
      classify("random", n % 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_gaps();
    test_restart();
    test_idle_err();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
